fetch_buffer_t: RTL

- Instruction prefetch stage between mem_t and the cpu_t decode front end.
- Issues sequential 3-byte reads to memory and queues returned bytes in a byte FIFO.
- Presents the next 3 queued bytes (opcode + up to 2 operands) with their PC.
- Consumer pops 1–3 bytes per cycle (instruction length); a redirect (branch/jump/reset vector) flushes the queue and restarts fetch.

---
 rtl/nes_cpu_pkg.sv | 16 +
 rtl/fetch_buffer_t_byte_fifo.sv | 76 +++++++
 rtl/fetch_buffer_t.sv | 128 ++++++++++++
 3 files changed

// File: rtl/nes_cpu_pkg.sv
// Shared CPU-wide definitions: memory address/byte sizes and the fetch buffer
// constants and state type used by fetch_buffer_t and byte_fifo_t.
package nes_cpu_pkg;

   localparam int MEM_ADDR_SIZE     = 16;
   localparam int BYTE              = 8;

   localparam int FETCH_BUF_DEPTH   = 8;
   localparam int FETCH_WIDTH_BYTES = 3;

   typedef enum logic {
      FILL  = 1'b0,
      FLUSH = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/fetch_buffer_t_byte_fifo.sv
// byte_fifo_t: circular byte queue with a 3-byte push, a 0-3 byte pop, a 3-byte
// head peek and a synchronous clear. The caller never pops more than avail_o.
module byte_fifo_t
   import nes_cpu_pkg::*;
#(
   parameter int DEPTH = FETCH_BUF_DEPTH
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic                               clear_i,
   input  logic                               push_i,
   input  logic [FETCH_WIDTH_BYTES*BYTE-1:0]  push_data_i,
   input  logic [1:0]                         pop_i,
   output logic [FETCH_WIDTH_BYTES*BYTE-1:0]  peek_o,
   output logic [1:0]                         avail_o,
   output logic [$clog2(DEPTH):0]             count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [BYTE-1:0] mem_q [DEPTH];
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_q, count_d;

   always_comb begin
      rd_ptr_d = rd_ptr_q + PW'(pop_i);
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q - CW'(pop_i);
      if (push_i) begin
         wr_ptr_d = wr_ptr_q + PW'(FETCH_WIDTH_BYTES);
         count_d  = count_d + CW'(FETCH_WIDTH_BYTES);
      end
      if (clear_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; pointers and count define what is valid.
   always_ff @(posedge clk_i) begin
      if (push_i && !clear_i) begin
         for (int i = 0; i < FETCH_WIDTH_BYTES; i++) begin
            mem_q[wr_ptr_q + PW'(i)] <= push_data_i[i*BYTE +: BYTE];
         end
      end
   end

   // Bytes past the valid count read as zero so the head is clean after reset.
   always_comb begin
      avail_o = (count_q >= CW'(FETCH_WIDTH_BYTES)) ? 2'd3 : count_q[1:0];
      peek_o  = '0;
      for (int i = 0; i < FETCH_WIDTH_BYTES; i++) begin
         if (2'(i) < avail_o) begin
            peek_o[i*BYTE +: BYTE] = mem_q[rd_ptr_q + PW'(i)];
         end
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/fetch_buffer_t.sv
// Instruction prefetch: sequential 3-byte memory reads into a byte FIFO, head
// presented with its PC. Optional counters enabled by FETCH_BUF_STATS_EN.
//
//   state | meaning
//   FILL  | normal operation, requests issued when 3 slots are free
//   FLUSH | one cycle after a redirect, no request issued
module fetch_buffer_t
   import nes_cpu_pkg::*;
#(
   parameter int                       DEPTH    = FETCH_BUF_DEPTH,
   parameter logic [MEM_ADDR_SIZE-1:0] RESET_PC = 16'hC000
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   output logic [MEM_ADDR_SIZE-1:0] mem_addr_o,
   output logic                     mem_req_o,
   input  logic [3*BYTE-1:0]        mem_data_i,
   input  logic                     redirect_i,
   input  logic [MEM_ADDR_SIZE-1:0] redirect_pc_i,
   input  logic [1:0]               consume_i,
   output logic [3*BYTE-1:0]        instr_bytes_o,
   output logic [1:0]               avail_o,
   output logic [MEM_ADDR_SIZE-1:0] pc_o
`ifdef FETCH_BUF_STATS_EN
   ,
   output logic [31:0]              stat_starve_o,
   output logic [15:0]              stat_flush_o
`endif
);

   localparam int            CW      = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] FETCH_C = CW'(FETCH_WIDTH_BYTES);

   fetch_state_e             state_q, state_d;
   logic [MEM_ADDR_SIZE-1:0] fetch_pc_q, fetch_pc_d;
   logic [MEM_ADDR_SIZE-1:0] pc_q, pc_d;
   logic                     inflight_q, inflight_d;
   logic                     discard_q, discard_d;
   logic [CW-1:0]            count;
   logic [1:0]               avail;
   logic [1:0]               pop;
   logic                     issue;
   logic                     push;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= FILL;
         fetch_pc_q <= RESET_PC;
         pc_q       <= RESET_PC;
         inflight_q <= 1'b0;
         discard_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         pc_q       <= pc_d;
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
      end
   end

   // Free space is judged on the registered count; one read in flight at most
   // means 3 slots are always reserved for the returning data.
   always_comb begin
      issue      = !rst_i && (state_q == FILL) && !inflight_q &&
                   ((DEPTH_C - count) >= FETCH_C);
      push       = inflight_q && !discard_q && !redirect_i;
      pop        = (consume_i > avail) ? avail : consume_i;
      state_d    = FILL;
      fetch_pc_d = fetch_pc_q;
      pc_d       = pc_q + MEM_ADDR_SIZE'(pop);
      inflight_d = issue;
      discard_d  = 1'b0;
      if (issue) begin
         fetch_pc_d = fetch_pc_q + MEM_ADDR_SIZE'(FETCH_WIDTH_BYTES);
      end
      // A read issued alongside the redirect returns stale data next cycle.
      if (redirect_i) begin
         state_d    = FLUSH;
         pop        = 2'd0;
         fetch_pc_d = redirect_pc_i;
         pc_d       = redirect_pc_i;
         discard_d  = issue;
      end
   end

   byte_fifo_t #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clear_i     (redirect_i),
      .push_i      (push),
      .push_data_i (mem_data_i),
      .pop_i       (pop),
      .peek_o      (instr_bytes_o),
      .avail_o     (avail),
      .count_o     (count)
   );

   assign mem_req_o  = issue;
   assign mem_addr_o = fetch_pc_q;
   assign avail_o    = avail;
   assign pc_o       = pc_q;

`ifdef FETCH_BUF_STATS_EN
   logic [31:0] starve_q;
   logic [15:0] flush_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         starve_q <= '0;
         flush_q  <= '0;
      end else begin
         if ((avail == 2'd0) && (starve_q != '1)) begin
            starve_q <= starve_q + 32'd1;
         end
         if (redirect_i && (flush_q != '1)) begin
            flush_q <= flush_q + 16'd1;
         end
      end
   end

   assign stat_starve_o = starve_q;
   assign stat_flush_o  = flush_q;
`endif

endmodule
